// File: rtl/simp_alu_74181.sv
// 4-bit carry-lookahead adder slice with group propagate/generate
// outputs for cascading, followed by one output register stage.
module simp_alu_74181 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout,
    output logic       Pout,
    output logic       Gout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic [3:0] sum_d;
    logic       pg_d;
    logic       gg_d;
    logic       co_d;

    assign g = A & B;
    assign p = A ^ B;

    // Every carry is a flat sum of products; no term depends on a lower carry
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & Cin);

    assign sum_d = p ^ c;

    assign pg_d = &p;
    assign gg_d = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign co_d = gg_d | (pg_d & Cin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= 4'h0;
            Cout <= 1'b0;
            Pout <= 1'b0;
            Gout <= 1'b0;
        end else begin
            S    <= sum_d;
            Cout <= co_d;
            Pout <= pg_d;
            Gout <= gg_d;
        end
    end

endmodule

// File: tb/tb_simp_alu_74181.sv
// Scoreboard bench for simp_alu_74181: stimulus queues expected
// results, a monitor compares them one edge later.
module tb_simp_alu_74181;

    typedef struct {
        logic [3:0] s;
        logic       c;
        logic       p;
        logic       g;
        int         tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic       cin = 1'b0;
    logic [3:0] s;
    logic       cout;
    logic       pout;
    logic       gout;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    simp_alu_74181 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (a),
        .B    (b),
        .Cin  (cin),
        .S    (s),
        .Cout (cout),
        .Pout (pout),
        .Gout (gout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int tag,
                       input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got S/C/P/G=%h expected %h",
                     nm, tag, act, exp);
        end
    endtask

    task automatic apply(input logic [3:0] ia, input logic [3:0] ib,
                         input logic ic, input logic [3:0] es,
                         input logic ec, input logic ep, input logic eg,
                         input int tag);
        exp_t e;
        @(negedge clk);
        a = ia;
        b = ib;
        cin = ic;
        e.s = es; e.c = ec; e.p = ep; e.g = eg; e.tag = tag;
        q.push_back(e);
    endtask

    // Monitor: every edge that consumed a queued stimulus is checked
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                #1;
                e = q.pop_front();
                chk("result", e.tag, {s, cout, pout, gout},
                    {e.s, e.c, e.p, e.g});
                chk("p_and_g", e.tag, {6'd0, pout & gout}, 7'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] ref_sum;
        logic [4:0] ref_gen;
        exp_t e;

        a = 4'hF; b = 4'hF; cin = 1'b1;
        #1;
        chk("reset_t0", 0, {s, cout, pout, gout}, 7'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", 0, {s, cout, pout, gout}, 7'd0);

        @(negedge clk);
        rst_n = 1'b1;
        e.s = 4'hF; e.c = 1'b1; e.p = 1'b0; e.g = 1'b1; e.tag = 1;
        q.push_back(e);

        apply(4'h1, 4'h2, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 10);
        apply(4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 11);
        apply(4'h5, 4'h6, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 12);
        apply(4'h7, 4'h8, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 20);
        apply(4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 21);
        apply(4'h9, 4'hA, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1, 30);
        apply(4'hB, 4'hC, 1'b0, 4'h7, 1'b1, 1'b0, 1'b1, 31);
        apply(4'hD, 4'hE, 1'b0, 4'hB, 1'b1, 1'b0, 1'b1, 32);
        apply(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 33);
        apply(4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 40);
        apply(4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 41);
        apply(4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 42);
        apply(4'h6, 4'h6, 1'b1, 4'hD, 1'b0, 1'b0, 1'b0, 43);

        // Mid-stream reset between edges discards the in-flight result
        apply(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 50);
        @(posedge clk);
        #2;
        chk("pre_reset", 50, {s, cout, pout, gout}, {4'hF, 3'b101});
        @(negedge clk);
        a = 4'h9; b = 4'h9; cin = 1'b0;
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_reset", 51, {s, cout, pout, gout}, 7'd0);
        @(posedge clk);
        #1;
        chk("reset_edge", 52, {s, cout, pout, gout}, 7'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 512; i++) begin
            logic [3:0] xa;
            logic [3:0] xb;
            logic       xc;
            xa = i[8:5];
            xb = i[4:1];
            xc = i[0];
            ref_sum = {1'b0, xa} + {1'b0, xb} + {4'd0, xc};
            ref_gen = {1'b0, xa} + {1'b0, xb};
            apply(xa, xb, xc, ref_sum[3:0], ref_sum[4],
                  (xa ^ xb) == 4'hF, ref_gen[4], 1000 + i);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 0, 7'(q.size()), 7'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/simp_alu_74181.md
Name: simp_alu_74181

Overview:
- 4-bit carry-lookahead adder slice in the style of the 74181 arithmetic path. Computes A+B+Cin and exports group propagate/generate for cascading into a higher-level lookahead carry unit.
- Combinational lookahead core followed by one output register stage.
- Used as the building block for wider CLA adders (16/32-bit via external lookahead).

Parameters:
- None. Width fixed at 4 bits.

Ports:
- clk  input  1  Single clock. All state updates on the rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- A  input  4  Operand A.
- B  input  4  Operand B.
- Cin  input  1  Carry in.
- S  output  4  Registered sum, (A+B+Cin) mod 16.
- Cout  output  1  Registered carry out of bit 3.
- Pout  output  1  Registered group propagate.
- Gout  output  1  Registered group generate.

Behaviour:
- Reset: rst_n low clears S=0, Cout=0, Pout=0, Gout=0 immediately, regardless of clk. Outputs hold 0 while rst_n is low. The first capture happens on the first rising clk after rst_n deasserts.
- Bit signals, for i = 0..3:
  - g_i = A_i & B_i
  - p_i = A_i ^ B_i (XOR propagate, so the sum reuses p)
- Internal carries, computed by lookahead with no ripple chain:
  - c0 = Cin
  - c1 = g0 | p0c0
  - c2 = g1 | p1g0 | p1p0c0
  - c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0
- Sum: S_i = p_i ^ c_i.
- Group terms:
  - Pout = p3&p2&p1&p0
  - Gout = g3 | p3g2 | p3p2g1 | p3p2p1g0
  - Cout = Gout | (Pout & Cin)
- Pout and Gout do not depend on Cin.
- Latency: exactly 1 cycle. Inputs present before rising edge k appear on the outputs after edge k. No handshake; a new operation is accepted every cycle.
- All four outputs update together from the same edge. No partial updates.
- Arithmetic: unsigned. Overflow wraps modulo 16 and is reported only through Cout. No signed-overflow flag.
- Pout and Gout are never both 1, because XOR propagate excludes generate at the same bit.
- Reset asserted mid-stream: outputs clear asynchronously. Any in-flight result is discarded.
- X/Z on inputs is not handled specially.

Test Plan:
- Hold rst_n=0 with A=F, B=F, Cin=1, clocking -> S=0, Cout=0, Pout=0, Gout=0. Release reset, one edge -> S=F, Cout=1, Pout=0, Gout=1.
- Basic sums, each checked one cycle after applying, Cin=0:
  - 1+2 -> S=3, Cout=0
  - 3+4 -> S=7, Cout=0
  - 5+6 -> S=B, Cout=0
- Full propagate, A=7, B=8, Cin=0 -> S=F, Cout=0, Pout=1, Gout=0. Same operands with Cin=1 -> S=0, Cout=1.
- Carry-out cases, Cin=0:
  - 9+A -> S=3, Cout=1
  - B+C -> S=7, Cout=1
  - D+E -> S=B, Cout=1
  - F+1 -> S=0, Cout=1, Pout=0, Gout=1
- Pipelining: change A/B/Cin every cycle -> each result appears exactly one edge later with no bubbles. Assert rst_n low between edges -> outputs drop to 0 immediately, before the next edge.
- Exhaustive: all 512 (A, B, Cin) combinations -> S and Cout match A+B+Cin. Pout and Gout match the reference equations, and Pout&Gout is always 0.
